vtx_bram_sched: RTL and testbench
=================================

Name: vtx_bram_sched

Overview:
- Scheduler in front of the 16-bank vertex BRAM (16 x 32-bit words per line, one read word per cycle).
- Sequences two phases:
  - LOAD: streams 512-bit self-addressed lines into the BRAM.
  - SERVE: round-robin shares the single read port among N_REQ edge-processing lanes, then routes each returned word to the lane that issued it.
- Never issues reads during LOAD or writes during SERVE.

Parameters:
- N_REQ, 4, number of read requesters (2..8).
- ADDR_W, 12, BRAM line-address width; word address is ADDR_W+4 bits.
- DATA_W, 32, read word width.
- RD_LAT, 2, cycles from bram_r_addr presented to bram_data_out valid.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- ld_valid  in  1  load line valid.
- ld_data  in  512  load line; bits [511:500] are the line write address.
- ld_last  in  1  marks the final load line.
- ld_ready  out  1  load line accepted when ld_valid&ld_ready.
- req_valid  in  N_REQ  per-lane read request.
- req_addr  in  N_REQ*(ADDR_W+4)  per-lane word address; lane i uses slice i.
- req_ready  out  N_REQ  one-hot grant; request accepted when valid&ready.
- rsp_valid  out  N_REQ  one-hot; lane i's read word is present.
- rsp_data  out  DATA_W  returned word, shared by all lanes.
- bram_data_in  out  512  to BRAM write data.
- bram_we  out  1  BRAM write enable.
- bram_r_addr  out  ADDR_W+4  BRAM read word address.
- bram_data_out  in  DATA_W  BRAM read data.
- load_done  out  1  high while in SERVE.
- busy  out  1  read pipeline non-empty.

Behaviour:

Reset values:
- state=IDLE, rr_ptr=0, pipeline cleared.
- All outputs 0: ld_ready, req_ready, rsp_valid, bram_we, bram_r_addr, bram_data_in, load_done, busy.

States:
- IDLE
  - ld_ready=1. First accepted line writes immediately and enters LOAD; if it also carries ld_last, go directly to SERVE.
  - req_valid is ignored; req_ready=0.
- LOAD
  - ld_ready=1. Each accepted line produces one cycle of bram_we=1 with bram_data_in=ld_data, driven combinationally from the handshake.
  - Accepted line with ld_last=1 -> SERVE on next cycle.
  - ld_valid=0 cycles are idle; no timeout.
- SERVE
  - load_done=1, ld_ready=0.
  - Each cycle, grant at most one lane: the first lane with req_valid=1 searching rr_ptr, rr_ptr+1, ... mod N_REQ.
  - req_ready=onehot(granted lane) is combinational from req_valid.
  - On a grant: bram_r_addr=req_addr slice of the granted lane, and rr_ptr <= granted+1 (mod N_REQ). With no grant, rr_ptr holds.
  - Total of 1 read/cycle; back-to-back grants allowed.
- DRAIN
  - Entered from SERVE when ld_valid=1 (reload request). Takes priority over reads: no new grants from the cycle ld_valid is seen.
  - Stay in DRAIN until pipeline empty (busy=0), then -> LOAD with ld_ready=1 the next cycle.
  - load_done=0 in DRAIN and LOAD.

Read pipeline:
- RD_LAT-deep shift register of {valid, lane index}.
- rsp_valid[lane]=1 exactly RD_LAT cycles after the accept cycle; rsp_data=bram_data_out in that cycle.
- No backpressure on responses; lanes must sink every word.
- Responses return in grant order.
- busy = OR of pipeline valids.

Boundary cases:
- rr_ptr wraps N_REQ-1 -> 0.
- All lanes requesting -> strict rotation, one grant per lane every N_REQ cycles.
- ld_valid rising during an in-flight read -> those responses are still delivered before LOAD.
- rst mid-LOAD or mid-SERVE -> pipeline flushed and in-flight responses dropped (no rsp_valid after rst).
- bram_we and a read grant are never asserted in the same cycle.

Optional Feature:
- Macro: VTX_SCHED_STATS_EN.
- Defined:
  - Adds outputs grant_cnt (32) and stall_cnt (32), both reset to 0 and wrapping at 2^32.
  - grant_cnt increments per accepted read.
  - stall_cnt increments per cycle in which some req_valid=1 is not granted (losing lanes or DRAIN).
- Undefined: ports and counters absent; no other behaviour change.

Test Plan:
1. Load: after rst, 3 lines with w_addr 0x000, 0x001, 0x7FF, last on third -> bram_we pulses 3 cycles, bram_data_in matches each line; load_done=1 exactly 1 cycle after the third accept.
2. Single read: in SERVE, lane 2 requests word addr 0x0013 -> req_ready=4'b0100 same cycle; bram_r_addr=0x0013; rsp_valid=4'b0100 RD_LAT=2 cycles later with rsp_data=bram_data_out.
3. Round-robin: all 4 lanes hold req_valid for 8 cycles from rr_ptr=0 -> grants 0,1,2,3,0,1,2,3; each lane gets 2 responses, in order.
4. Reload drain: read granted to lane 1, then ld_valid asserted next cycle -> no further grants; lane 1's rsp_valid still arrives; ld_ready rises only after busy=0.
5. Reset mid-flight: grant lane 3, assert rst the following cycle -> no rsp_valid afterwards; all outputs 0; state IDLE.
6. With VTX_SCHED_STATS_EN: in scenario 3, grant_cnt=8 and stall_cnt=8 (every cycle has losing lanes).

Source files
------------

// File: rtl/vtx_bram_sched_if.sv
// Bus bundle for the vertex BRAM scheduler: load stream, per-lane read
// requests/responses and the raw BRAM port.
interface vtx_bram_sched_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // Handshakes: a transfer happens in a cycle where valid&ready are both 1;
  // ready may depend combinationally on valid, and responses have no ready.
  logic                          ld_valid;
  logic [511:0]                  ld_data;
  logic                          ld_last;
  logic                          ld_ready;
  logic [N_REQ-1:0]              req_valid;
  logic [N_REQ*(ADDR_W+4)-1:0]   req_addr;
  logic [N_REQ-1:0]              req_ready;
  logic [N_REQ-1:0]              rsp_valid;
  logic [DATA_W-1:0]             rsp_data;
  logic [511:0]                  bram_data_in;
  logic                          bram_we;
  logic [ADDR_W+3:0]             bram_r_addr;
  logic [DATA_W-1:0]             bram_data_out;
  logic                          load_done;
  logic                          busy;

  modport slave (
    input  ld_valid, ld_data, ld_last, req_valid, req_addr, bram_data_out,
    output ld_ready, req_ready, rsp_valid, rsp_data, bram_data_in, bram_we,
           bram_r_addr, load_done, busy
  );

  modport master (
    output ld_valid, ld_data, ld_last, req_valid, req_addr, bram_data_out,
    input  ld_ready, req_ready, rsp_valid, rsp_data, bram_data_in, bram_we,
           bram_r_addr, load_done, busy
  );
endinterface

// File: rtl/vtx_bram_sched.sv
// Load/serve scheduler for the 16-bank vertex BRAM with a round-robin read port.
// Define VTX_SCHED_STATS_EN to add the grant_cnt/stall_cnt statistics outputs.
module vtx_bram_sched #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  vtx_bram_sched_if.slave       bus,
  output logic [1:0]            state_dbg
`ifdef VTX_SCHED_STATS_EN
  ,
  output logic [31:0]           grant_cnt,
  output logic [31:0]           stall_cnt
`endif
);
  localparam int WA_W  = ADDR_W + 4;
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SERVE = 2'd2, DRAIN = 2'd3} state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  rr_ptr, rr_nxt;
  logic [RD_LAT-1:0] pipe_v;
  logic [PTR_W-1:0]  pipe_lane [RD_LAT];
  logic [WA_W-1:0]   lane_addr [N_REQ];
  logic              ld_rdy, ld_acc, gnt_found, grant, in_flight;
  logic [PTR_W-1:0]  gnt_idx, idx;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign lane_addr[i] = bus.req_addr[i*WA_W +: WA_W];
  end

  assign state_dbg = state;
  assign in_flight = |pipe_v;
  assign ld_rdy    = !rst && (state == IDLE || state == LOAD);
  assign ld_acc    = ld_rdy && bus.ld_valid;
  // A pending reload blocks new grants in the very cycle it is seen.
  assign grant     = !rst && (state == SERVE) && !bus.ld_valid && gnt_found;

  // Scan downward so the lane closest to rr_ptr is the last (winning) write.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(rr_ptr) + k) % N_REQ);
      if (bus.req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE:    if (ld_acc) state_nxt = bus.ld_last ? SERVE : LOAD;
      LOAD:    if (ld_acc && bus.ld_last) state_nxt = SERVE;
      SERVE:   if (bus.ld_valid) state_nxt = DRAIN;
      DRAIN:   if (!in_flight) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
    if (grant) rr_nxt = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
  end

  // Every output is forced low while rst is high, even though state is registered.
  always_comb begin
    bus.ld_ready     = ld_rdy;
    bus.bram_we      = ld_acc;
    bus.bram_data_in = ld_acc ? bus.ld_data : '0;
    bus.req_ready    = '0;
    bus.bram_r_addr  = '0;
    bus.rsp_valid    = '0;
    bus.rsp_data     = '0;
    bus.load_done    = !rst && (state == SERVE);
    bus.busy         = !rst && in_flight;
    if (grant) begin
      bus.req_ready[gnt_idx] = 1'b1;
      bus.bram_r_addr        = lane_addr[gnt_idx];
    end
    if (!rst && pipe_v[RD_LAT-1]) begin
      bus.rsp_valid[pipe_lane[RD_LAT-1]] = 1'b1;
      bus.rsp_data                       = bus.bram_data_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      pipe_v <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_lane[i] <= '0;
    end else begin
      state        <= state_nxt;
      rr_ptr       <= rr_nxt;
      pipe_v[0]    <= grant;
      pipe_lane[0] <= gnt_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_lane[i] <= pipe_lane[i-1];
      end
    end
  end

`ifdef VTX_SCHED_STATS_EN
  logic stall_cyc;
  assign stall_cyc = !rst && (state == SERVE || state == DRAIN) &&
                     |(bus.req_valid & ~bus.req_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (grant)     grant_cnt <= grant_cnt + 32'd1;
      if (stall_cyc) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_vtx_bram_sched.sv
// Self-checking bench for vtx_bram_sched: directed load/arbitration tables,
// randomized arbitration against a rotation model, drain and reset corners.
module tb_vtx_bram_sched;
  localparam int N_REQ  = 4;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;
  localparam int EW     = 32 + N_REQ + DATA_W;

  typedef struct {
    logic [N_REQ-1:0] rv;
    logic [N_REQ-1:0] exp_rdy;
    logic [15:0]      exp_addr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  logic [15:0]   lane_a [N_REQ];
  logic [15:0]   rd_a1, rd_a2;
  vec_t          tbl [12];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vtx_bram_sched_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef VTX_SCHED_STATS_EN
  logic [31:0] grant_cnt, stall_cnt;
`endif

  vtx_bram_sched #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
`ifdef VTX_SCHED_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  // BRAM model: word at address a reads back as {~a, a}, RD_LAT cycles later.
  always @(posedge clk) begin
    rd_a1 <= bus.bram_r_addr;
    rd_a2 <= rd_a1;
  end
  assign bus.bram_data_out = {~rd_a2, rd_a2};

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [511:0] mk_line(input logic [11:0] a);
    return {a, {15{32'hC0DE_0000 | 32'(a)}}, 20'h5A5A5};
  endfunction

  task automatic push_rsp(input int lane, input logic [15:0] addr);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[lane] = 1'b1;
    exp_q.push_back({32'(cyc + RD_LAT), oh, ~addr, addr});
  endtask

  task automatic set_addrs();
    bus.req_addr = {lane_a[3], lane_a[2], lane_a[1], lane_a[0]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response scoreboard: each cycle either the queue head is due or nothing may arrive.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0) mon_e = exp_q[0];
      else mon_e = '0;
      if (exp_q.size() > 0 && int'(mon_e[EW-1 -: 32]) == cyc) begin
        chk("rsp_valid", bus.rsp_valid, mon_e[DATA_W +: N_REQ]);
        chk("rsp_data", bus.rsp_data, mon_e[DATA_W-1:0]);
        void'(exp_q.pop_front());
      end else begin
        chk("rsp_quiet", bus.rsp_valid, '0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_m;
    int g;
    int lane;
    bit found;
    logic [N_REQ-1:0] rv;
    logic [N_REQ-1:0] exp_rdy;

    // Arbitration table, starting from rr_ptr=3 (after the single lane-2 read).
    tbl[0]  = '{4'b0000, 4'b0000, 16'h0000};
    tbl[1]  = '{4'b0100, 4'b0100, 16'h0013};
    tbl[2]  = '{4'b0011, 4'b0001, 16'h1000};
    tbl[3]  = '{4'b1111, 4'b0010, 16'h2013};
    tbl[4]  = '{4'b1001, 4'b1000, 16'h4039};
    tbl[5]  = '{4'b1000, 4'b1000, 16'h4039};
    tbl[6]  = '{4'b0110, 4'b0010, 16'h2013};
    tbl[7]  = '{4'b0000, 4'b0000, 16'h0000};
    tbl[8]  = '{4'b0001, 4'b0001, 16'h1000};
    tbl[9]  = '{4'b1101, 4'b0100, 16'h0013};
    tbl[10] = '{4'b1011, 4'b1000, 16'h4039};
    tbl[11] = '{4'b0011, 4'b0001, 16'h1000};

    lane_a[0] = 16'h1000;
    lane_a[1] = 16'h2013;
    lane_a[2] = 16'h0013;
    lane_a[3] = 16'h4039;
    set_addrs();

    // Reset with every input active: outputs must all stay low.
    rst           = 1'b1;
    bus.ld_valid  = 1'b1;
    bus.ld_data   = mk_line(12'h123);
    bus.ld_last   = 1'b1;
    bus.req_valid = '1;
    tick();
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_ld_ready", bus.ld_ready, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_bram_we", bus.bram_we, 0);
    chk("rst_bram_r_addr", bus.bram_r_addr, 0);
    chk("rst_bram_data_in", bus.bram_data_in, 0);
    chk("rst_load_done", bus.load_done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_state", state_dbg, 0);
    tick();

    // Load: 0x000, idle gap, 0x001, 0x7FF(last); requests ignored meanwhile.
    rst          = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = mk_line(12'h000);
    bus.ld_last  = 1'b0;
    @(negedge clk);
    chk("ld0_state_idle", state_dbg, 0);
    chk("ld0_ready", bus.ld_ready, 1);
    chk("ld0_we", bus.bram_we, 1);
    chk("ld0_data", bus.bram_data_in, mk_line(12'h000));
    chk("ld0_req_ready", bus.req_ready, 0);
    tick();
    bus.ld_valid = 1'b0;
    @(negedge clk);
    chk("ldgap_state", state_dbg, 1);
    chk("ldgap_we", bus.bram_we, 0);
    chk("ldgap_data", bus.bram_data_in, 0);
    chk("ldgap_ready", bus.ld_ready, 1);
    chk("ldgap_req_ready", bus.req_ready, 0);
    tick();
    bus.ld_valid = 1'b1;
    bus.ld_data  = mk_line(12'h001);
    @(negedge clk);
    chk("ld1_we", bus.bram_we, 1);
    chk("ld1_data", bus.bram_data_in, mk_line(12'h001));
    tick();
    bus.ld_data = mk_line(12'h7FF);
    bus.ld_last = 1'b1;
    @(negedge clk);
    chk("ld2_we", bus.bram_we, 1);
    chk("ld2_data", bus.bram_data_in, mk_line(12'h7FF));
    chk("ld2_load_done", bus.load_done, 0);
    tick();
    bus.ld_valid  = 1'b0;
    bus.ld_last   = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    chk("serve_load_done", bus.load_done, 1);
    chk("serve_ld_ready", bus.ld_ready, 0);
    chk("serve_state", state_dbg, 2);
    tick();

    // Round-robin: all lanes for 8 cycles from rr_ptr=0.
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = '1;
      @(negedge clk);
      chk("rr_ready", bus.req_ready, 4'b0001 << (i % N_REQ));
      chk("rr_addr", bus.bram_r_addr, lane_a[i % N_REQ]);
      chk("rr_no_we", bus.bram_we, 0);
      push_rsp(i % N_REQ, lane_a[i % N_REQ]);
      tick();
    end
    bus.req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rr_tail_busy", bus.busy, (i < 2) ? 1 : 0);
      tick();
    end
`ifdef VTX_SCHED_STATS_EN
    chk("grant_cnt", grant_cnt, 8);
    chk("stall_cnt", stall_cnt, 8);
`endif

    // Single read from lane 2 at word 0x0013.
    bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("single_ready", bus.req_ready, 4'b0100);
    chk("single_addr", bus.bram_r_addr, 16'h0013);
    push_rsp(2, 16'h0013);
    tick();

    for (int i = 0; i < 12; i++) begin
      bus.req_valid = tbl[i].rv;
      @(negedge clk);
      chk("tbl_ready", bus.req_ready, tbl[i].exp_rdy);
      chk("tbl_addr", bus.bram_r_addr, tbl[i].exp_addr);
      for (int l = 0; l < N_REQ; l++)
        if (tbl[i].exp_rdy[l]) push_rsp(l, tbl[i].exp_addr);
      tick();
    end

    // Randomized arbitration against a rotation model (pointer is at lane 1 here).
    rr_m = 1;
    for (int n = 0; n < 200; n++) begin
      rv = N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
      for (int l = 0; l < N_REQ; l++) lane_a[l] = 16'($urandom_range(0, 65535));
      set_addrs();
      bus.req_valid = rv;
      found = 1'b0;
      g = 0;
      for (int k = 0; k < N_REQ; k++)
        if (!found && rv[(rr_m + k) % N_REQ]) begin
          found = 1'b1;
          g = (rr_m + k) % N_REQ;
        end
      exp_rdy = found ? N_REQ'(1 << g) : '0;
      if (found) rr_m = (g + 1) % N_REQ;
      @(negedge clk);
      chk("rand_ready", bus.req_ready, exp_rdy);
      chk("rand_addr", bus.bram_r_addr, found ? lane_a[g] : 16'h0000);
      if (found) push_rsp(g, lane_a[g]);
      tick();
    end
    bus.req_valid = '0;
    repeat (4) tick();

    // Reload drain: lane 1 read, then ld_valid the next cycle.
    bus.req_valid = 4'b0010;
    @(negedge clk);
    chk("drain_grant", bus.req_ready, 4'b0010);
    push_rsp(1, lane_a[1]);
    tick();
    bus.req_valid = '1;
    bus.ld_valid  = 1'b1;
    bus.ld_data   = mk_line(12'h055);
    bus.ld_last   = 1'b1;
    @(negedge clk);
    chk("drain_t1_ready", bus.req_ready, 0);
    chk("drain_t1_ld_ready", bus.ld_ready, 0);
    chk("drain_t1_busy", bus.busy, 1);
    chk("drain_t1_we", bus.bram_we, 0);
    tick();
    @(negedge clk);
    chk("drain_t2_state", state_dbg, 3);
    chk("drain_t2_ready", bus.req_ready, 0);
    chk("drain_t2_ld_ready", bus.ld_ready, 0);
    chk("drain_t2_load_done", bus.load_done, 0);
    tick();
    @(negedge clk);
    chk("drain_t3_busy", bus.busy, 0);
    chk("drain_t3_ld_ready", bus.ld_ready, 0);
    tick();
    @(negedge clk);
    chk("reload_state", state_dbg, 1);
    chk("reload_ld_ready", bus.ld_ready, 1);
    chk("reload_we", bus.bram_we, 1);
    chk("reload_data", bus.bram_data_in, mk_line(12'h055));
    chk("reload_req_ready", bus.req_ready, 0);
    tick();
    bus.ld_valid  = 1'b0;
    bus.ld_last   = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    chk("reload_done", bus.load_done, 1);
    tick();

    // Reset the cycle after a lane-3 grant: the response must never appear.
    bus.req_valid = 4'b1000;
    @(negedge clk);
    chk("rstmid_grant", bus.req_ready, 4'b1000);
    push_rsp(3, lane_a[3]);
    tick();
    rst           = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    exp_q.delete();
    chk("rstmid_busy", bus.busy, 0);
    chk("rstmid_ld_ready", bus.ld_ready, 0);
    chk("rstmid_load_done", bus.load_done, 0);
    chk("rstmid_r_addr", bus.bram_r_addr, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_state", state_dbg, 0);
    chk("rstmid_ld_ready_idle", bus.ld_ready, 1);
    chk("rstmid_busy_after", bus.busy, 0);
    tick();
    repeat (3) tick();

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) tick();
    chk("exp_q_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
